// File: rtl/div_sqrt_postprocess_pkg.sv
// Shared constants and types for the FP32 divide/sqrt back-end.
// Widths, rounding-mode encodings, canonical results and flag positions.
// Imported by the interface, the rounding helper and the top.
package fpu_defs_div_sqrt_tp;

  localparam int C_OP   = 32;
  localparam int C_EXP  = 8;
  localparam int C_MANT = 23;
  localparam int C_RM   = 3;
  localparam int C_BIAS = 127;

  // width of the underflow shift amount (saturates at C_MANT+2)
  localparam int C_SHW = $clog2(C_MANT + 3);

  localparam logic [C_RM-1:0] C_RM_NEAREST     = 3'h0;
  localparam logic [C_RM-1:0] C_RM_TRUNC       = 3'h1;
  localparam logic [C_RM-1:0] C_RM_MINUS       = 3'h2;
  localparam logic [C_RM-1:0] C_RM_PLUS        = 3'h3;
  localparam logic [C_RM-1:0] C_RM_NEAREST_MAX = 3'h4;

  localparam logic [C_OP-1:0] C_QNAN       = 32'h7FC0_0000;
  localparam logic [C_OP-1:0] C_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [C_OP-1:0] C_INF        = 32'h7F80_0000;

  // all-ones biased exponent; any rounded exponent at or above it overflows
  localparam logic [C_EXP+1:0] C_EXP_MAX = (C_EXP+2)'(2 * C_BIAS + 1);

  localparam int C_FLAG_NV = 4;
  localparam int C_FLAG_DZ = 3;
  localparam int C_FLAG_OF = 2;
  localparam int C_FLAG_UF = 1;
  localparam int C_FLAG_NX = 0;

  // stage-1 contents: normalized pre-rounding value plus resolved special case
  typedef struct packed {
    logic              sign;
    logic [C_RM-1:0]   rm;
    logic [C_EXP+1:0]  exp;
    logic [C_MANT:0]   mant;
    logic              rnd;
    logic              stk;
    logic              tiny;
    logic              spec;
    logic [C_OP-1:0]   spec_res;
    logic [4:0]        spec_flags;
  } s1_t;

endpackage

// File: rtl/div_sqrt_postprocess_if.sv
// Handshake and data bundle between the iteration core, this back-end and the consumer.
// slave: the back-end itself; master: the iteration core plus result consumer.
// Clock, reset and flush stay as plain ports.
interface div_sqrt_postprocess_if;
  import fpu_defs_div_sqrt_tp::*;

  logic               Done_SI;
  logic               In_ready_SO;
  logic               Div_SI;
  logic [C_MANT+2:0]  Mant_z_DI;
  logic               Sticky_SI;
  logic [C_EXP+1:0]   Exp_z_DI;
  logic               Sign_z_DI;
  logic [C_RM-1:0]    RM_SI;
  logic               Inf_a_SI;
  logic               Inf_b_SI;
  logic               Zero_a_SI;
  logic               Zero_b_SI;
  logic               NaN_a_SI;
  logic               NaN_b_SI;
  logic               SNaN_SI;
  logic [C_OP-1:0]    Result_DO;
  logic [4:0]         Fflags_SO;
  logic               Valid_SO;
  logic               Ready_SI;

  modport slave (
    input  Done_SI, Div_SI, Mant_z_DI, Sticky_SI, Exp_z_DI, Sign_z_DI, RM_SI,
           Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI, SNaN_SI,
           Ready_SI,
    output In_ready_SO, Result_DO, Fflags_SO, Valid_SO
  );

  modport master (
    output Done_SI, Div_SI, Mant_z_DI, Sticky_SI, Exp_z_DI, Sign_z_DI, RM_SI,
           Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI, SNaN_SI,
           Ready_SI,
    input  In_ready_SO, Result_DO, Fflags_SO, Valid_SO
  );

endinterface

// File: rtl/div_sqrt_round.sv
// Round-increment decision and mantissa/exponent carry for a normalized or subnormal value.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module div_sqrt_round
  import fpu_defs_div_sqrt_tp::*;
(
  input  logic [C_MANT:0]   Mant_DI,
  input  logic [C_EXP+1:0]  Exp_DI,
  input  logic              Round_SI,
  input  logic              Sticky_SI,
  input  logic              Sign_SI,
  input  logic [C_RM-1:0]   RM_SI,
  output logic [C_MANT-1:0] Mant_DO,
  output logic [C_EXP+1:0]  Exp_DO,
  output logic              Inexact_SO
);

  logic              inc;
  logic [C_MANT+1:0] sum;

  // increment decision; unused encodings fall back to nearest-even
  always_comb begin
    inc = 1'b0;
    case (RM_SI)
      C_RM_TRUNC:       inc = 1'b0;
      C_RM_MINUS:       inc = (Round_SI | Sticky_SI) & Sign_SI;
      C_RM_PLUS:        inc = (Round_SI | Sticky_SI) & ~Sign_SI;
      C_RM_NEAREST_MAX: inc = Round_SI;
      default:          inc = Round_SI & (Sticky_SI | Mant_DI[0]);
    endcase
  end

  assign sum        = {1'b0, Mant_DI} + {{(C_MANT+1){1'b0}}, inc};
  assign Inexact_SO = Round_SI | Sticky_SI;

  // carry out of 1.11..1 renormalizes to 1.0 with exponent+1; a subnormal carry into the hidden bit becomes exponent 1
  always_comb begin
    Mant_DO = sum[C_MANT-1:0];
    Exp_DO  = Exp_DI;
    if (sum[C_MANT+1]) begin
      Mant_DO = sum[C_MANT:1];
      Exp_DO  = Exp_DI + {{(C_EXP+1){1'b0}}, 1'b1};
    end else if (Exp_DI == '0) begin
      Exp_DO  = {{(C_EXP+1){1'b0}}, sum[C_MANT]};
    end
  end

endmodule

// File: rtl/div_sqrt_postprocess.sv
// FP32 divide/sqrt back-end: normalize, denormalize on underflow, round, resolve specials.
// Latency: Done_SI accepted at cycle t gives Valid_SO at t+2, specials included.
// Backpressure: both stages hold while Valid_SO & ~Ready_SI; In_ready_SO drops once stage 1 is also full.
module div_sqrt_postprocess
  import fpu_defs_div_sqrt_tp::*;
(
  input logic                  Clk_CI,
  input logic                  Rst_RBI,
  input logic                  Kill_SI,
  div_sqrt_postprocess_if.slave io
);

  logic                s1_vld, valid_q, s2_adv, in_ready, accept;
  s1_t                 s1_d, s1_q;
  logic [C_EXP+2:0]    exp_ext, exp_norm, ufl_dist;
  logic [C_MANT:0]     mant_norm;
  logic                rnd_norm, stk_norm, is_ufl;
  logic [C_SHW-1:0]    shamt;
  logic [2*C_MANT+3:0] shift_vec;
  logic [C_OP-1:0]     zero_res, inf_res, res_d, res_q;
  logic [4:0]          fl_d, fl_q;
  logic [C_MANT-1:0]   rnd_mant;
  logic [C_EXP+1:0]    rnd_exp;
  logic                rnd_nx, ovf, sat_max;

  assign s2_adv   = ~valid_q | io.Ready_SI;
  assign in_ready = ~s1_vld | s2_adv;
  assign accept   = io.Done_SI & in_ready;

  assign io.In_ready_SO = in_ready;
  assign io.Valid_SO    = valid_q;
  assign io.Result_DO   = res_q;
  assign io.Fflags_SO   = fl_q;

  assign exp_ext  = {io.Exp_z_DI[C_EXP+1], io.Exp_z_DI};
  assign zero_res = {io.Sign_z_DI, {(C_OP-1){1'b0}}};
  assign inf_res  = {io.Sign_z_DI, C_INF[C_OP-2:0]};

  // normalize to 1.x, then shift into the subnormal range when the exponent is not positive
  always_comb begin
    if (io.Mant_z_DI[C_MANT+2]) begin
      exp_norm  = exp_ext;
      mant_norm = io.Mant_z_DI[C_MANT+2:2];
      rnd_norm  = io.Mant_z_DI[1];
      stk_norm  = io.Mant_z_DI[0] | io.Sticky_SI;
    end else begin
      exp_norm  = exp_ext - {{(C_EXP+2){1'b0}}, 1'b1};
      mant_norm = io.Mant_z_DI[C_MANT+1:1];
      rnd_norm  = io.Mant_z_DI[0];
      stk_norm  = io.Sticky_SI;
    end
    is_ufl   = exp_norm[C_EXP+2] | (exp_norm == '0);
    ufl_dist = {{(C_EXP+2){1'b0}}, 1'b1} - exp_norm;
    shamt    = (ufl_dist > (C_EXP+3)'(C_MANT+2)) ? C_SHW'(C_MANT+2) : ufl_dist[C_SHW-1:0];
    if (!is_ufl) shamt = '0;
    shift_vec = {mant_norm, rnd_norm, {(C_MANT+2){1'b0}}} >> shamt;
  end

  // stage-1 payload: rounding inputs plus the special-case result in priority order
  always_comb begin
    s1_d            = '0;
    s1_d.sign       = io.Sign_z_DI;
    s1_d.rm         = io.RM_SI;
    s1_d.tiny       = is_ufl;
    s1_d.exp        = is_ufl ? '0 : exp_norm[C_EXP+1:0];
    s1_d.mant       = shift_vec[2*C_MANT+3:C_MANT+3];
    s1_d.rnd        = shift_vec[C_MANT+2];
    s1_d.stk        = stk_norm | (|shift_vec[C_MANT+1:0]);
    s1_d.spec       = 1'b1;
    s1_d.spec_res   = C_QNAN;
    if (io.Div_SI) begin
      if (io.NaN_a_SI | io.NaN_b_SI)
        s1_d.spec_flags[C_FLAG_NV] = io.SNaN_SI;
      else if ((io.Zero_a_SI & io.Zero_b_SI) | (io.Inf_a_SI & io.Inf_b_SI))
        s1_d.spec_flags[C_FLAG_NV] = 1'b1;
      else if (io.Inf_a_SI)
        s1_d.spec_res = inf_res;
      else if (io.Zero_b_SI) begin
        s1_d.spec_res              = inf_res;
        s1_d.spec_flags[C_FLAG_DZ] = 1'b1;
      end else if (io.Zero_a_SI | io.Inf_b_SI)
        s1_d.spec_res = zero_res;
      else
        s1_d.spec = 1'b0;
    end else begin
      if (io.NaN_a_SI)
        s1_d.spec_flags[C_FLAG_NV] = io.SNaN_SI;
      else if (io.Zero_a_SI)
        s1_d.spec_res = zero_res;
      else if (io.Sign_z_DI)
        s1_d.spec_flags[C_FLAG_NV] = 1'b1;
      else if (io.Inf_a_SI)
        s1_d.spec_res = inf_res;
      else
        s1_d.spec = 1'b0;
    end
  end

  // stage 1 register; flush wins over a simultaneous capture
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (Kill_SI)       s1_vld <= 1'b0;
      else if (in_ready) s1_vld <= accept;
      if (accept)        s1_q   <= s1_d;
    end
  end

  div_sqrt_round i_round (
    .Mant_DI    (s1_q.mant),
    .Exp_DI     (s1_q.exp),
    .Round_SI   (s1_q.rnd),
    .Sticky_SI  (s1_q.stk),
    .Sign_SI    (s1_q.sign),
    .RM_SI      (s1_q.rm),
    .Mant_DO    (rnd_mant),
    .Exp_DO     (rnd_exp),
    .Inexact_SO (rnd_nx)
  );

  assign ovf     = (rnd_exp >= C_EXP_MAX);
  assign sat_max = (s1_q.rm == C_RM_TRUNC) |
                   ((s1_q.rm == C_RM_MINUS) & ~s1_q.sign) |
                   ((s1_q.rm == C_RM_PLUS) & s1_q.sign);

  // final result and flags: specials first, then overflow, else the rounded number
  always_comb begin
    res_d            = {s1_q.sign, rnd_exp[C_EXP-1:0], rnd_mant};
    fl_d             = '0;
    fl_d[C_FLAG_NX]  = rnd_nx;
    fl_d[C_FLAG_UF]  = s1_q.tiny & rnd_nx;
    if (s1_q.spec) begin
      res_d = s1_q.spec_res;
      fl_d  = s1_q.spec_flags;
    end else if (ovf) begin
      res_d           = sat_max ? {s1_q.sign, C_MAX_FINITE[C_OP-2:0]} : {s1_q.sign, C_INF[C_OP-2:0]};
      fl_d            = '0;
      fl_d[C_FLAG_OF] = 1'b1;
      fl_d[C_FLAG_NX] = 1'b1;
    end
  end

  // stage 2 output register; data only changes on a real advance so it holds under backpressure
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      fl_q    <= '0;
    end else begin
      if (Kill_SI)     valid_q <= 1'b0;
      else if (s2_adv) valid_q <= s1_vld;
      if (s2_adv && s1_vld) begin
        res_q <= res_d;
        fl_q  <= fl_d;
      end
    end
  end

endmodule

// File: tb/tb_div_sqrt_postprocess.sv
// Scoreboard bench for the divide/sqrt back-end: expected results are queued at acceptance
// and compared in order as results leave the pipe; handshake, flush and reset are probed directly.
module tb_div_sqrt_postprocess;
  import fpu_defs_div_sqrt_tp::*;

  logic Clk_CI  = 1'b0;
  logic Rst_RBI = 1'b0;
  logic Kill_SI = 1'b0;

  div_sqrt_postprocess_if dsp_if ();

  div_sqrt_postprocess dut (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .Kill_SI (Kill_SI),
    .io      (dsp_if.slave)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   id_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // in-order output checker, sampled mid-cycle
  always @(negedge Clk_CI) begin
    if (Rst_RBI && dsp_if.Valid_SO && dsp_if.Ready_SI) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {31'b0, dsp_if.Valid_SO}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq($sformatf("res#%0d", mon_e.id), dsp_if.Result_DO, mon_e.res);
        check_eq($sformatf("flags#%0d", mon_e.id), {27'b0, dsp_if.Fflags_SO}, {27'b0, mon_e.fl});
      end
    end
  end

  task automatic push_exp(input logic [31:0] eres, input logic [4:0] efl);
    exp_t e;
    e.id  = 16'(id_cnt);
    e.res = eres;
    e.fl  = efl;
    exp_q.push_back(e);
    id_cnt++;
  endtask

  // cls = {inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}
  task automatic set_in(input logic div, input logic [25:0] mant, input logic stk,
                        input logic [9:0] ex, input logic sgn, input logic [2:0] rm,
                        input logic [5:0] cls, input logic snan);
    dsp_if.Div_SI    = div;
    dsp_if.Mant_z_DI = mant;
    dsp_if.Sticky_SI = stk;
    dsp_if.Exp_z_DI  = ex;
    dsp_if.Sign_z_DI = sgn;
    dsp_if.RM_SI     = rm;
    {dsp_if.Inf_a_SI, dsp_if.Inf_b_SI, dsp_if.Zero_a_SI,
     dsp_if.Zero_b_SI, dsp_if.NaN_a_SI, dsp_if.NaN_b_SI} = cls;
    dsp_if.SNaN_SI   = snan;
  endtask

  task automatic send(input logic div, input logic [25:0] mant, input logic stk,
                      input logic [9:0] ex, input logic sgn, input logic [2:0] rm,
                      input logic [5:0] cls, input logic snan,
                      input logic [31:0] eres, input logic [4:0] efl);
    bit ok;
    ok = 1'b0;
    set_in(div, mant, stk, ex, sgn, rm, cls, snan);
    dsp_if.Done_SI = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk_CI);
      if (dsp_if.In_ready_SO) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push_exp(eres, efl);
    else    check_eq("send_timeout", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    @(posedge Clk_CI);
    #1;
    dsp_if.Done_SI = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge Clk_CI);
      n++;
    end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    dsp_if.Done_SI  = 1'b0;
    dsp_if.Ready_SI = 1'b1;
    set_in(1'b0, 26'h0, 1'b0, 10'h0, 1'b0, 3'd0, 6'b0, 1'b0);

    // reset state
    repeat (3) @(posedge Clk_CI);
    #1;
    check_eq("rst0_valid", {31'b0, dsp_if.Valid_SO}, 32'd0);
    check_eq("rst0_result", dsp_if.Result_DO, 32'd0);
    check_eq("rst0_flags", {27'b0, dsp_if.Fflags_SO}, 32'd0);
    check_eq("rst0_in_ready", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    Rst_RBI = 1'b1;
    @(posedge Clk_CI);
    #1;

    // first result and its two-cycle latency
    send(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b0, 0, 32'h4000_0000, 5'h00);
    @(negedge Clk_CI);
    check_eq("lat_t1", {31'b0, dsp_if.Valid_SO}, 32'd0);
    @(negedge Clk_CI);
    check_eq("lat_t2", {31'b0, dsp_if.Valid_SO}, 32'd1);
    @(posedge Clk_CI);
    #1;

    // rounding, normalization, overflow, underflow and specials back to back
    send(1, 26'h2000002, 0, 10'd127, 0, 3'd0, 6'b0, 0, 32'h3F80_0000, 5'h01);
    send(1, 26'h2000002, 0, 10'd127, 0, 3'd3, 6'b0, 0, 32'h3F80_0001, 5'h01);
    send(1, 26'h2000002, 0, 10'd127, 1, 3'd2, 6'b0, 0, 32'hBF80_0001, 5'h01);
    send(1, 26'h2000002, 0, 10'd127, 0, 3'd4, 6'b0, 0, 32'h3F80_0001, 5'h01);
    send(1, 26'h2000002, 0, 10'd127, 0, 3'd7, 6'b0, 0, 32'h3F80_0000, 5'h01);
    send(1, 26'h1000000, 0, 10'd127, 0, 3'd0, 6'b0, 0, 32'h3F00_0000, 5'h00);
    send(1, 26'h1000000, 1, 10'd127, 0, 3'd0, 6'b0, 0, 32'h3F00_0000, 5'h01);
    send(1, 26'h3FFFFFE, 0, 10'd127, 0, 3'd0, 6'b0, 0, 32'h4000_0000, 5'h01);
    send(1, 26'h2000000, 0, 10'd255, 0, 3'd0, 6'b0, 0, 32'h7F80_0000, 5'h05);
    send(1, 26'h2000000, 0, 10'd255, 0, 3'd1, 6'b0, 0, 32'h7F7F_FFFF, 5'h05);
    send(1, 26'h2000000, 0, 10'd255, 0, 3'd2, 6'b0, 0, 32'h7F7F_FFFF, 5'h05);
    send(1, 26'h2000000, 0, 10'd255, 1, 3'd3, 6'b0, 0, 32'hFF7F_FFFF, 5'h05);
    send(1, 26'h2000000, 0, 10'h3E2, 0, 3'd0, 6'b0, 0, 32'h0000_0000, 5'h03);
    send(1, 26'h2000000, 0, 10'h3E2, 0, 3'd3, 6'b0, 0, 32'h0000_0001, 5'h03);
    send(1, 26'h2000000, 0, 10'd0,   0, 3'd0, 6'b0, 0, 32'h0040_0000, 5'h00);
    send(1, 26'h1FFFFFF, 0, 10'd1,   0, 3'd0, 6'b0, 0, 32'h0080_0000, 5'h03);
    send(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b001100, 0, 32'h7FC0_0000, 5'h10);
    send(1, 26'h2000000, 0, 10'd128, 1, 3'd0, 6'b000100, 0, 32'hFF80_0000, 5'h08);
    send(1, 26'h2000000, 0, 10'd128, 1, 3'd0, 6'b100000, 0, 32'hFF80_0000, 5'h00);
    send(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b001000, 0, 32'h0000_0000, 5'h00);
    send(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b000010, 1, 32'h7FC0_0000, 5'h10);
    send(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b000001, 0, 32'h7FC0_0000, 5'h00);
    send(0, 26'h2000000, 0, 10'd128, 1, 3'd0, 6'b0, 0, 32'h7FC0_0000, 5'h10);
    send(0, 26'h2000000, 0, 10'd128, 1, 3'd0, 6'b001000, 0, 32'h8000_0000, 5'h00);
    send(0, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b100000, 0, 32'h7F80_0000, 5'h00);
    drain("main_drain");

    // backpressure: third request refused, results held then released in order
    @(posedge Clk_CI);
    #1;
    dsp_if.Ready_SI = 1'b0;
    set_in(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b0, 0);
    dsp_if.Done_SI = 1'b1;
    @(negedge Clk_CI);
    check_eq("bp_rdy_a", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    push_exp(32'h4000_0000, 5'h00);
    @(posedge Clk_CI);
    #1;
    set_in(1, 26'h2000002, 0, 10'd127, 0, 3'd3, 6'b0, 0);
    @(negedge Clk_CI);
    check_eq("bp_rdy_b", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    push_exp(32'h3F80_0001, 5'h01);
    @(posedge Clk_CI);
    #1;
    set_in(1, 26'h1000000, 0, 10'd127, 0, 3'd0, 6'b0, 0);
    @(negedge Clk_CI);
    check_eq("bp_refuse", {31'b0, dsp_if.In_ready_SO}, 32'd0);
    check_eq("bp_valid", {31'b0, dsp_if.Valid_SO}, 32'd1);
    check_eq("bp_hold_res", dsp_if.Result_DO, 32'h4000_0000);
    @(posedge Clk_CI);
    #1;
    @(negedge Clk_CI);
    check_eq("bp_refuse2", {31'b0, dsp_if.In_ready_SO}, 32'd0);
    check_eq("bp_stable_res", dsp_if.Result_DO, 32'h4000_0000);
    @(posedge Clk_CI);
    #1;
    dsp_if.Ready_SI = 1'b1;
    @(negedge Clk_CI);
    check_eq("bp_rdy_c", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    push_exp(32'h3F00_0000, 5'h00);
    @(posedge Clk_CI);
    #1;
    dsp_if.Done_SI = 1'b0;
    drain("bp_drain");

    // flush with both stages occupied
    @(posedge Clk_CI);
    #1;
    dsp_if.Ready_SI = 1'b0;
    set_in(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b0, 0);
    dsp_if.Done_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    set_in(1, 26'h1000000, 0, 10'd127, 0, 3'd0, 6'b0, 0);
    @(posedge Clk_CI);
    #1;
    dsp_if.Done_SI = 1'b0;
    Kill_SI = 1'b1;
    @(negedge Clk_CI);
    check_eq("kill_pre_valid", {31'b0, dsp_if.Valid_SO}, 32'd1);
    @(posedge Clk_CI);
    #1;
    Kill_SI = 1'b0;
    @(negedge Clk_CI);
    check_eq("kill_valid", {31'b0, dsp_if.Valid_SO}, 32'd0);
    check_eq("kill_in_ready", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    dsp_if.Ready_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    @(negedge Clk_CI);
    check_eq("kill_s1_empty", {31'b0, dsp_if.Valid_SO}, 32'd0);

    // flush beats a simultaneous capture
    @(posedge Clk_CI);
    #1;
    set_in(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b0, 0);
    dsp_if.Done_SI = 1'b1;
    Kill_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    dsp_if.Done_SI = 1'b0;
    Kill_SI = 1'b0;
    @(posedge Clk_CI);
    #1;
    @(negedge Clk_CI);
    check_eq("kill_wins", {31'b0, dsp_if.Valid_SO}, 32'd0);

    // asynchronous reset with a result waiting
    @(posedge Clk_CI);
    #1;
    dsp_if.Ready_SI = 1'b0;
    set_in(1, 26'h2000000, 0, 10'd128, 0, 3'd0, 6'b0, 0);
    dsp_if.Done_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    dsp_if.Done_SI = 1'b0;
    @(posedge Clk_CI);
    #1;
    check_eq("rst_pre_valid", {31'b0, dsp_if.Valid_SO}, 32'd1);
    #2;
    Rst_RBI = 1'b0;
    #1;
    check_eq("rst_valid", {31'b0, dsp_if.Valid_SO}, 32'd0);
    check_eq("rst_result", dsp_if.Result_DO, 32'd0);
    check_eq("rst_flags", {27'b0, dsp_if.Fflags_SO}, 32'd0);
    check_eq("rst_in_ready", {31'b0, dsp_if.In_ready_SO}, 32'd1);
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    repeat (2) @(posedge Clk_CI);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
